// File: rtl/rd_job_sched_pkg.sv
// Shared types and helpers for the host-read job scheduler and the
// request arbiter it uses.
package rd_job_sched_pkg;

    // Width of every line-count quantity seen by the read engine.
    localparam int LEN_W = 64;

    // Scheduler sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LAUNCH     = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_COMPLETE   = 3'd4
    } t_sched_state;

    // Requester index, wide enough for the largest supported requester count (8).
    typedef logic [2:0] t_req_id;

    // Size of the next engine run: what is left of the job, capped at the chunk limit.
    function automatic logic [LEN_W-1:0] min_chunk(input logic [LEN_W-1:0] rem,
                                                   input logic [LEN_W-1:0] max_len);
        return (rem < max_len) ? rem : max_len;
    endfunction

endpackage

// File: rtl/rd_job_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping around. Returns both a one-hot grant and its index.
module rr_arbiter
    import rd_job_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     gnt_any
);

    localparam int IDW = $clog2(N_REQ);

    logic [IDW-1:0] cand;

    // Scan requesters starting at ptr; the first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDW'((int'(ptr) + k) % N_REQ);
            if (!gnt_any && req[cand]) begin
                gnt_any   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rd_job_sched.sv
// Host-read job scheduler: arbitrates requesters round-robin, splits each
// job into engine runs of at most MAX_CHUNK lines and reports completion.
// Optional per-requester statistics are built when RD_JOB_SCHED_STATS_EN
// is defined.
module rd_job_sched
    import rd_job_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int AW        = 42,
    parameter int MAX_CHUNK = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*AW-1:0]      req_addr,
    input  logic [N_REQ*LEN_W-1:0]   req_len,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     cmp_valid,
    output logic [$clog2(N_REQ)-1:0] cmp_id,
    output logic                     rd_run,
    output logic [AW-1:0]            rd_first_clAddr,
    output logic [LEN_W-1:0]         rd_data_length,
    input  logic                     rd_done,
    output logic                     busy
`ifdef RD_JOB_SCHED_STATS_EN
    ,
    output logic [N_REQ*64-1:0]      stat_lines,
    output logic [N_REQ*32-1:0]      stat_jobs
`endif
);

    localparam int IDW = $clog2(N_REQ);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHUNK);

    t_sched_state     state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   cur_id_q, cur_id_d;
    logic [IDW-1:0]   cmp_id_q, cmp_id_d;
    logic [AW-1:0]    cur_addr_q, cur_addr_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] rd_len_q, rd_len_d;
    logic             rd_run_q, rd_run_d;
    logic             cmp_valid_q, cmp_valid_d;

    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_any;
    logic             accept;
    logic [AW-1:0]    nxt_addr;
    logic [LEN_W-1:0] nxt_rem;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Nothing is accepted while reset is held, so req_ready stays low then.
    assign accept    = reset && (state_q == ST_IDLE) && gnt_any;
    assign req_ready = accept ? gnt : '0;

    // Position after the chunk currently on the engine (address may wrap).
    assign nxt_addr = cur_addr_q + AW'(rd_len_q);
    assign nxt_rem  = rem_q - rd_len_q;

    // Sequencer next-state: engine command and completion pulses are
    // registered on the transition into LAUNCH / COMPLETE.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_id_d    = cur_id_q;
        cur_addr_d  = cur_addr_q;
        rem_d       = rem_q;
        rd_addr_d   = rd_addr_q;
        rd_len_d    = rd_len_q;
        cmp_id_d    = cmp_id_q;
        rd_run_d    = 1'b0;
        cmp_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cur_addr_d = req_addr[int'(gnt_idx)*AW +: AW];
                    rem_d      = req_len[int'(gnt_idx)*LEN_W +: LEN_W];
                    cur_id_d   = gnt_idx;
                    rr_ptr_d   = IDW'((int'(gnt_idx) + 1) % N_REQ);
                    if (rem_d == '0) begin
                        state_d     = ST_COMPLETE;
                        cmp_valid_d = 1'b1;
                        cmp_id_d    = gnt_idx;
                    end else begin
                        state_d   = ST_LAUNCH;
                        rd_run_d  = 1'b1;
                        rd_addr_d = cur_addr_d;
                        rd_len_d  = min_chunk(rem_d, MAX_LEN);
                    end
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_START;
            end
            // The engine still reports done in the cycle after a run pulse.
            ST_WAIT_START: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (rd_done) begin
                    cur_addr_d = nxt_addr;
                    rem_d      = nxt_rem;
                    if (nxt_rem == '0) begin
                        state_d     = ST_COMPLETE;
                        cmp_valid_d = 1'b1;
                        cmp_id_d    = cur_id_q;
                    end else begin
                        state_d   = ST_LAUNCH;
                        rd_run_d  = 1'b1;
                        rd_addr_d = nxt_addr;
                        rd_len_d  = min_chunk(nxt_rem, MAX_LEN);
                    end
                end
            end
            ST_COMPLETE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            rd_run_q    <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_id_q    <= '0;
            rd_addr_q   <= '0;
            rd_len_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            rd_run_q    <= rd_run_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_id_q    <= cmp_id_d;
            rd_addr_q   <= rd_addr_d;
            rd_len_q    <= rd_len_d;
        end
    end

    // Job progress registers; always reloaded on accept, so no reset needed.
    always_ff @(posedge clk) begin
        cur_id_q   <= cur_id_d;
        cur_addr_q <= cur_addr_d;
        rem_q      <= rem_d;
    end

    assign rd_run          = rd_run_q;
    assign rd_first_clAddr = rd_addr_q;
    assign rd_data_length  = rd_len_q;
    assign cmp_valid       = cmp_valid_q;
    assign cmp_id          = cmp_id_q;
    assign busy            = (state_q != ST_IDLE);

`ifdef RD_JOB_SCHED_STATS_EN
    logic [N_REQ-1:0][63:0] lines_q, lines_d;
    logic [N_REQ-1:0][31:0] jobs_q, jobs_d;

    function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[64] ? '1 : s[63:0];
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] a);
        return (a == '1) ? a : a + 32'd1;
    endfunction

    // Credit finished lines and finished jobs to the requester being served.
    always_comb begin
        lines_d = lines_q;
        jobs_d  = jobs_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(cur_id_q) == i) begin
                if ((state_q == ST_WAIT_DONE) && rd_done) begin
                    lines_d[i] = sat_add64(lines_q[i], rd_len_q);
                end
                if (cmp_valid_q) begin
                    jobs_d[i] = sat_inc32(jobs_q[i]);
                end
            end
        end
    end

    // Statistics counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lines_q <= '0;
            jobs_q  <= '0;
        end else begin
            lines_q <= lines_d;
            jobs_q  <= jobs_d;
        end
    end

    assign stat_lines = lines_q;
    assign stat_jobs  = jobs_q;
`endif

endmodule

// File: tb/tb_rd_job_sched.sv
// Self-checking bench for rd_job_sched: directed jobs followed by random
// job batches, compared against a job-level reference model.
module tb_rd_job_sched;

    localparam int N   = 4;
    localparam int AW  = 42;
    localparam int MAX = 64;

    typedef logic [63:0] u64;

    logic               clk;
    logic               reset;
    logic [N-1:0]       req_valid;
    logic [N*AW-1:0]    req_addr;
    logic [N*64-1:0]    req_len;
    logic [N-1:0]       req_ready;
    logic               cmp_valid;
    logic [1:0]         cmp_id;
    logic               rd_run;
    logic [AW-1:0]      rd_first_clAddr;
    logic [63:0]        rd_data_length;
    logic               rd_done;
    logic               busy;
`ifdef RD_JOB_SCHED_STATS_EN
    logic [N*64-1:0]    stat_lines;
    logic [N*32-1:0]    stat_jobs;
`endif

    rd_job_sched #(.N_REQ(N), .AW(AW), .MAX_CHUNK(MAX)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_len         (req_len),
        .req_ready       (req_ready),
        .cmp_valid       (cmp_valid),
        .cmp_id          (cmp_id),
        .rd_run          (rd_run),
        .rd_first_clAddr (rd_first_clAddr),
        .rd_data_length  (rd_data_length),
        .rd_done         (rd_done),
        .busy            (busy)
`ifdef RD_JOB_SCHED_STATS_EN
        ,
        .stat_lines      (stat_lines),
        .stat_jobs       (stat_jobs)
`endif
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Observed events with cycle stamps
    int q_gnt_id[$];
    int q_gnt_cyc[$];
    int q_cmp_id[$];
    int q_cmp_cyc[$];
    u64 q_run_addr[$];
    u64 q_run_len[$];
    int q_run_cyc[$];
    int q_done_cyc[$];

    // Reference model state
    int mptr = 0;
    u64 m_lines[N];
    u64 m_jobs[N];
    u64 b_addr[N];
    u64 b_len[N];
    u64 amask;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input u64 obs, input u64 exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        q_gnt_id.delete();  q_gnt_cyc.delete();
        q_cmp_id.delete();  q_cmp_cyc.delete();
        q_run_addr.delete(); q_run_len.delete();
        q_run_cyc.delete(); q_done_cyc.delete();
    endtask

    task automatic check_stats();
`ifdef RD_JOB_SCHED_STATS_EN
        for (int i = 0; i < N; i++) begin
            check("stat_lines", stat_lines[i*64 +: 64], m_lines[i]);
            check("stat_jobs", {32'd0, stat_jobs[i*32 +: 32]}, m_jobs[i]);
        end
`endif
    endtask

    // Engine model: done stays high through the cycle after rd_run, then
    // drops for a random 1..4 cycles before returning high.
    initial begin : engine
        bit running;
        int tmr;
        int dly;
        u64 e_addr;
        u64 e_len;
        running = 0;
        tmr     = 0;
        dly     = 1;
        e_addr  = '0;
        e_len   = '0;
        rd_done = 1'b1;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                running = 0;
                rd_done = 1'b1;
            end else if (running) begin
                check("eng_addr_stable", {22'd0, rd_first_clAddr}, e_addr);
                check("eng_len_stable", rd_data_length, e_len);
                check("eng_no_rerun", {63'd0, rd_run}, 64'd0);
                check("eng_busy", {63'd0, busy}, 64'd1);
                tmr++;
                if (tmr == 1) rd_done = 1'b0;
                if (tmr == 1 + dly) begin
                    rd_done = 1'b1;
                    running = 0;
                    q_done_cyc.push_back(cyc);
                end
            end else if (rd_run === 1'b1) begin
                running = 1;
                tmr     = 0;
                dly     = $urandom_range(1, 4);
                e_addr  = {22'd0, rd_first_clAddr};
                e_len   = rd_data_length;
                q_run_addr.push_back(e_addr);
                q_run_len.push_back(e_len);
                q_run_cyc.push_back(cyc);
            end
        end
    end

    // Requester side: log grants/completions, drop valid after acceptance.
    initial begin : monitor
        logic [N-1:0] drop;
        drop = '0;
        forever begin
            @(negedge clk);
            req_valid = req_valid & ~drop;
            drop = '0;
            if (req_ready !== '0) begin
                check("ready_onehot", {63'd0, $onehot(req_ready)}, 64'd1);
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i] === 1'b1) begin
                        q_gnt_id.push_back(i);
                        q_gnt_cyc.push_back(cyc);
                    end
                end
                drop = req_ready;
            end
            if (cmp_valid === 1'b1) begin
                q_cmp_id.push_back(int'(cmp_id));
                q_cmp_cyc.push_back(cyc);
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, {60'd0, req_ready}, 64'd0);
        check({tag, "_cmp_valid"}, {63'd0, cmp_valid}, 64'd0);
        check({tag, "_cmp_id"}, {62'd0, cmp_id}, 64'd0);
        check({tag, "_rd_run"}, {63'd0, rd_run}, 64'd0);
        check({tag, "_rd_addr"}, {22'd0, rd_first_clAddr}, 64'd0);
        check({tag, "_rd_len"}, rd_data_length, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    // Present all requesters in mask at once with b_addr/b_len, then compare
    // grants, engine runs, completions and timing with the model.
    task automatic run_batch(input logic [N-1:0] mask);
        int order[$];
        int nrun[$];
        u64 ex_a[$];
        u64 ex_l[$];
        logic [N-1:0] pend;
        u64 a;
        u64 r;
        u64 c;
        int ri;
        int prev;
        int pick;
        pend = mask;
        while (pend != '0) begin
            pick = -1;
            for (int k = 0; k < N; k++) begin
                if (pick < 0 && pend[(mptr + k) % N]) pick = (mptr + k) % N;
            end
            order.push_back(pick);
            pend[pick] = 1'b0;
            mptr = (pick + 1) % N;
        end
        foreach (order[j]) begin
            a = b_addr[order[j]];
            r = b_len[order[j]];
            nrun.push_back(0);
            while (r > 0) begin
                c = (r < MAX) ? r : u64'(MAX);
                ex_a.push_back(a);
                ex_l.push_back(c);
                nrun[j] = nrun[j] + 1;
                a = (a + c) & amask;
                r = r - c;
            end
            m_lines[order[j]] += b_len[order[j]];
            m_jobs[order[j]]  += 1;
        end

        clear_logs();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                req_addr[i*AW +: AW] = b_addr[i][AW-1:0];
                req_len[i*64 +: 64]  = b_len[i];
            end
        end
        req_valid = req_valid | mask;
        for (int t = 0; t < 20000 && q_cmp_id.size() < order.size(); t++) @(posedge clk);
        repeat (3) @(posedge clk);

        check("n_grants", q_gnt_id.size(), order.size());
        check("n_cmps", q_cmp_id.size(), order.size());
        check("n_runs", q_run_addr.size(), ex_a.size());
        foreach (order[j]) begin
            if (j < q_gnt_id.size()) check("gnt_id", q_gnt_id[j], order[j]);
            if (j < q_cmp_id.size()) check("cmp_id", q_cmp_id[j], order[j]);
        end
        foreach (ex_a[k]) begin
            if (k < q_run_addr.size()) begin
                check("run_addr", q_run_addr[k], ex_a[k]);
                check("run_len", q_run_len[k], ex_l[k]);
            end
        end
        ri = 0;
        foreach (order[j]) begin
            if (j < q_gnt_cyc.size() && j < q_cmp_cyc.size()) begin
                if (j > 0) check("gnt_after_cmp", q_gnt_cyc[j], q_cmp_cyc[j-1] + 1);
                prev = q_gnt_cyc[j];
                for (int n = 0; n < nrun[j]; n++) begin
                    if (ri < q_run_cyc.size() && ri < q_done_cyc.size()) begin
                        check("run_latency", q_run_cyc[ri], prev + 1);
                        prev = q_done_cyc[ri];
                    end
                    ri++;
                end
                check("cmp_latency", q_cmp_cyc[j], prev + 1);
            end
        end
        @(negedge clk);
        check("idle_busy", {63'd0, busy}, 64'd0);
        check_stats();
    endtask

    initial begin : main
        logic [N-1:0] mask;
        int sel;
        amask = (64'd1 << AW) - 64'd1;
        for (int i = 0; i < N; i++) begin
            m_lines[i] = '0; m_jobs[i] = '0; b_addr[i] = '0; b_len[i] = '0;
        end
        reset     = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_valid = '0;
        req_len[63:0] = 64'd5;
        req_valid[0]  = 1'b1;

        // Held in reset with a request pending: everything stays quiet
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        check_stats();
        @(posedge clk); #1;
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);

        // Single job
        b_addr[0] = 64'h1000; b_len[0] = 64'd10;
        run_batch(4'b0001);
        // Chunked job
        b_addr[1] = 64'h2000; b_len[1] = 64'd150;
        run_batch(4'b0010);
        // Zero-length job
        b_addr[2] = 64'h2800; b_len[2] = 64'd0;
        run_batch(4'b0100);
        // Zero-length job on 3 brings the pointer back to 0
        b_addr[3] = 64'h0; b_len[3] = 64'd0;
        run_batch(4'b1000);
        // Round robin 0,1,3, then 0 again ahead of 1
        b_addr[0] = 64'h10; b_len[0] = 64'd1;
        b_addr[1] = 64'h20; b_len[1] = 64'd1;
        b_addr[3] = 64'h30; b_len[3] = 64'd1;
        run_batch(4'b1011);
        run_batch(4'b0011);

        // Reset in the middle of a long job
        clear_logs();
        @(posedge clk); #1;
        req_addr[0 +: AW] = 42'h5000;
        req_len[0 +: 64]  = 64'd100;
        req_valid[0]      = 1'b1;
        for (int t = 0; t < 100 && rd_done !== 1'b0; t++) @(negedge clk);
        check("midreset_engine_busy", {63'd0, rd_done}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        check("midreset_no_cmp", q_cmp_id.size(), 0);
        mptr = 0;
        for (int i = 0; i < N; i++) begin
            m_lines[i] = '0; m_jobs[i] = '0;
        end
        check_stats();
        b_addr[2] = 64'h3000; b_len[2] = 64'd70;
        run_batch(4'b0100);

        // Random batches
        for (int round = 0; round < 16; round++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) b_addr[i] = amask - u64'($urandom_range(0, 100));
                else b_addr[i] = {$urandom(), $urandom()} & amask;
                sel = $urandom_range(0, 3);
                case (sel)
                    0:       b_len[i] = 64'd0;
                    1:       b_len[i] = u64'($urandom_range(1, 64));
                    2:       b_len[i] = u64'($urandom_range(65, 300));
                    default: b_len[i] = u64'($urandom_range(1, 3));
                endcase
            end
            run_batch(mask);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
